eee_hblur3: RTL and testbench
=============================

# eee_hblur3

Horizontal 3-tap smoothing stage that sits directly upstream of the EEE_IMGPROC colour-detection block on the Avalon-ST video path. It takes 24-bit RGB packets and applies a per-channel [1 2 1]/4 filter along each line to suppress single-pixel sensor noise before HSV thresholding. Control packets, packet descriptors (SOP words) and bypass-mode traffic pass through unmodified. A one-beat hold register supplies each pixel's right-hand neighbour.

## Interface
Parameters:
- IMAGE_W, 640, pixels per line
- IMAGE_H, 480, lines per frame

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- sink_data  in  24  {R,G,B} pixel or descriptor word
- sink_valid  in  1  input beat valid
- sink_sop / sink_eop  in  1 each  packet delimiters
- sink_ready  out  1  input accepted when sink_valid & sink_ready (ready latency 0)
- source_data  out  24  output word
- source_valid  out  1  output beat valid
- source_sop / source_eop  out  1 each  delimiters, aligned with the data they came with
- source_ready  in  1  downstream ready
- mode  in  1  1 = filter enabled, 0 = bypass
- frame_count  out  16  number of completed video packets, wraps at 0xFFFF
- size_err  out  1  sticky: last video packet had a pixel count other than IMAGE_W*IMAGE_H

## Operation
- Hold register H (valid, data, sop, eop, x, video) stores one beat. Output register O (valid, data, sop, eop) drives the source port.
- out_free = ~O.valid | source_ready.
- sink_ready = out_free & ~(H.valid & H.eop).
- accept = sink_valid & sink_ready.
- Emit H into O when H.valid & out_free & (accept | H.eop). After an emit, O.valid = 1. Otherwise O.valid is cleared when source_ready is high.
- On accept: the new beat loads into H.
- An H.eop beat is emitted without waiting for a next beat, and H.valid then clears. This forces exactly one input bubble per packet.
- Packet type: on an SOP beat, video = (sink_data[3:0] == 0). The flag applies to all following beats of that packet.
- Filtering applies only when mode & H.video & ~H.sop. Otherwise the output equals H.data.
- Filter, per channel, using 10-bit arithmetic: out = (L + 2C + R) >> 2, truncated.
  - C = H pixel.
  - L = previous emitted video pixel of the same line; L = C when H.x == 0.
  - R = sink_data; R = C when H.x == IMAGE_W-1, or H.eop, or sink_sop.
  - The maximum sum is 1020, so the result always fits in 8 bits and needs no saturation.
- Counters x (0..IMAGE_W-1, wraps to 0 with y+1) and y:
  - SOP resets both to 0.
  - Counters advance on each accepted non-SOP video beat.
  - H.x latches the x of the held pixel.
- When a video EOP is emitted:
  - frame_count increments.
  - size_err is set if the pixel total ≠ IMAGE_W*IMAGE_H.
  - size_err clears when an EOP with the correct count is emitted.
- An SOP arriving while H holds a non-EOP beat (truncated packet): H is emitted with R = C, and the new SOP is loaded normally.
- mode is sampled at the emit cycle.

## Timing
- Reset values: source_valid 0, source_data 0, source_sop 0, source_eop 0, frame_count 0, size_err 0. H.valid = 0. sink_ready is 1 after reset, since out_free holds.
- Latency:
  - Beat n appears on source the cycle after beat n+1 is accepted.
  - An EOP beat appears 2 cycles after its acceptance, given source_ready stays high.
- Throughput is 1 beat per cycle within a packet, plus 1 bubble cycle per EOP.
- Backpressure: when source_ready is low with O.valid set, sink_ready drops in the same cycle, and O, H and L hold their values.
- Reset asserted mid-packet: all state clears, and the partial packet is discarded. Downstream resynchronises on the next SOP.

## Structure
- Shared package eee_video_pkg holds:
  - IMAGE_W/IMAGE_H defaults
  - pixel typedef {r, g, b} of 8 bits each
  - VIDEO_DESC_NIBBLE = 4'h0
- Sub-module eee_hblur3_px: a combinational single-channel (L + 2C + R) >> 2, instantiated 3×.
- The handshake, hold logic and counters stay in the top module. Target size is ~200 lines.

## Test plan
- Line of pixels R channel 0, 0, 100, 0, 0 (G = B = 0), mode = 1 → output R 0, 25, 50, 25, 0.
- Edge replication: x0 = 200, x1 = 40 → out x0 = (200 + 400 + 40) >> 2 = 160. Last pixel of line 255 with left neighbour 255 → 255.
- mode = 0, or control packet (descriptor nibble ≠ 0) → output bit-identical to input, including the SOP word. frame_count unchanged for the control packet.
- source_ready toggled at random 50%, full 640×480 frame → no loss or duplication. Output matches the reference model. EOP followed by exactly one bubble. frame_count = 1, size_err = 0.
- Truncated frame (EOP after 1000 pixels) → size_err = 1. The next correct frame → size_err = 0, frame_count = 2.
- reset_n low for 1 cycle mid-line → source_valid = 0 the next cycle. The following frame output is correct from its SOP.

Source files
------------

// File: rtl/eee_video_pkg.sv
// Shared video definitions for the EEE image-processing path.
// Holds the default frame geometry, the RGB pixel layout and the
// descriptor nibble that marks an Avalon-ST video packet.
package eee_video_pkg;

    localparam int unsigned IMAGE_W_DEF = 640;
    localparam int unsigned IMAGE_H_DEF = 480;
    localparam int unsigned CH_W        = 8;
    localparam int unsigned PIX_W       = 3 * CH_W;

    // Low nibble of the SOP word identifying a video (not control) packet
    localparam logic [3:0] VIDEO_DESC_NIBBLE = 4'h0;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;

    // True when a packet descriptor nibble announces video data
    function automatic logic is_video_desc(input logic [3:0] nib);
        return nib == VIDEO_DESC_NIBBLE;
    endfunction

endpackage

// File: rtl/eee_hblur3_px.sv
// Single-channel [1 2 1]/4 smoothing kernel, purely combinational.
// Ports:
//   left, centre, right : 8-bit neighbour samples
//   smooth_c            : (left + 2*centre + right) >> 2, truncated
// The 10-bit sum peaks at 1020, so the shifted result always fits 8 bits.
module eee_hblur3_px
    import eee_video_pkg::*;
(
    input  logic [CH_W-1:0] left,
    input  logic [CH_W-1:0] centre,
    input  logic [CH_W-1:0] right,
    output logic [CH_W-1:0] smooth_c
);

    localparam int unsigned SUM_W = CH_W + 2;

    logic [SUM_W-1:0] sum;

    assign sum      = SUM_W'(left) + {1'b0, centre, 1'b0} + SUM_W'(right);
    assign smooth_c = CH_W'(sum >> 2);

endmodule

// File: rtl/eee_hblur3.sv
// Horizontal 3-tap [1 2 1]/4 smoothing stage for 24-bit RGB Avalon-ST video.
// A one-beat hold register supplies the right-hand neighbour of each pixel;
// control packets, SOP descriptor words and bypass traffic pass unchanged.
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   sink_*                  : Avalon-ST input (data/valid/sop/eop/ready, RL 0)
//   source_*                : Avalon-ST output (data/valid/sop/eop/ready)
//   mode                    : 1 = filter enabled, 0 = bypass
//   frame_count             : completed video packets, wraps at 0xFFFF
//   size_err                : last video packet had the wrong pixel count
module eee_hblur3
    import eee_video_pkg::*;
#(
    parameter int unsigned IMAGE_W = IMAGE_W_DEF,
    parameter int unsigned IMAGE_H = IMAGE_H_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] sink_data,
    input  logic             sink_valid,
    input  logic             sink_sop,
    input  logic             sink_eop,
    output logic             sink_ready,
    output logic [PIX_W-1:0] source_data,
    output logic             source_valid,
    output logic             source_sop,
    output logic             source_eop,
    input  logic             source_ready,
    input  logic             mode,
    output logic [15:0]      frame_count,
    output logic             size_err
);

    localparam int unsigned XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam int unsigned YW = 16;
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_FULL = YW'(IMAGE_H);

    // Hold register H
    logic          h_valid;
    logic          h_sop;
    logic          h_eop;
    logic          h_video;
    logic [XW-1:0] h_x;
    pixel_t        h_pix;

    // Output register O
    logic          o_valid;
    logic          o_sop;
    logic          o_eop;
    pixel_t        o_pix;

    // Raw value of the previously emitted video pixel (left neighbour)
    pixel_t        l_pix;

    // Position of the next incoming pixel and current packet type
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          pkt_video;

    logic          out_free;
    logic          accept;
    logic          emit;
    logic          beat_video;
    logic          filt_en;
    logic          count_ok;
    pixel_t        in_pix;
    pixel_t        left_pix;
    pixel_t        right_pix;
    pixel_t        filt_pix;
    pixel_t        emit_pix;

    // Handshake: H drains into O; a held EOP blocks input for one cycle
    assign out_free   = ~o_valid | source_ready;
    assign sink_ready = out_free & ~(h_valid & h_eop);
    assign accept     = sink_valid & sink_ready;
    assign emit       = h_valid & out_free & (accept | h_eop);

    assign in_pix     = pixel_t'(sink_data);
    assign beat_video = sink_sop ? is_video_desc(sink_data[3:0]) : pkt_video;

    // Edge replication: line start reuses C as L; line end, packet end,
    // a truncating SOP or a missing next beat reuse C as R
    assign left_pix  = (h_x == '0) ? h_pix : l_pix;
    assign right_pix = ((h_x == X_LAST) | h_eop | sink_sop | ~accept) ? h_pix : in_pix;

    eee_hblur3_px u_px_r (
        .left     (left_pix.r),
        .centre   (h_pix.r),
        .right    (right_pix.r),
        .smooth_c (filt_pix.r)
    );

    eee_hblur3_px u_px_g (
        .left     (left_pix.g),
        .centre   (h_pix.g),
        .right    (right_pix.g),
        .smooth_c (filt_pix.g)
    );

    eee_hblur3_px u_px_b (
        .left     (left_pix.b),
        .centre   (h_pix.b),
        .right    (right_pix.b),
        .smooth_c (filt_pix.b)
    );

    assign filt_en  = mode & h_video & ~h_sop;
    assign emit_pix = filt_en ? filt_pix : h_pix;

    // After exactly IMAGE_W*IMAGE_H pixels the counters sit at (0, IMAGE_H)
    assign count_ok = (x_cnt == '0) & (y_cnt == Y_FULL);

    assign source_data  = o_pix;
    assign source_valid = o_valid;
    assign source_sop   = o_sop;
    assign source_eop   = o_eop;

    // Datapath, position counters and frame statistics
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_valid     <= 1'b0;
            h_sop       <= 1'b0;
            h_eop       <= 1'b0;
            h_video     <= 1'b0;
            h_x         <= '0;
            h_pix       <= '0;
            o_valid     <= 1'b0;
            o_sop       <= 1'b0;
            o_eop       <= 1'b0;
            o_pix       <= '0;
            l_pix       <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            pkt_video   <= 1'b0;
            frame_count <= '0;
            size_err    <= 1'b0;
        end else begin
            if (emit) begin
                o_valid <= 1'b1;
                o_pix   <= emit_pix;
                o_sop   <= h_sop;
                o_eop   <= h_eop;
            end else if (source_ready) begin
                o_valid <= 1'b0;
            end

            if (accept) begin
                h_valid <= 1'b1;
                h_pix   <= in_pix;
                h_sop   <= sink_sop;
                h_eop   <= sink_eop;
                h_video <= beat_video;
                h_x     <= sink_sop ? '0 : x_cnt;
            end else if (emit) begin
                h_valid <= 1'b0;
            end

            if (emit & h_video & ~h_sop) begin
                l_pix <= h_pix;
            end

            if (accept) begin
                if (sink_sop) begin
                    x_cnt     <= '0;
                    y_cnt     <= '0;
                    pkt_video <= beat_video;
                end else if (pkt_video) begin
                    if (x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        // Saturate so oversized packets never alias a good count
                        if (y_cnt != '1) begin
                            y_cnt <= y_cnt + YW'(1);
                        end
                    end else begin
                        x_cnt <= x_cnt + XW'(1);
                    end
                end
            end

            if (emit & h_eop & h_video) begin
                frame_count <= frame_count + 16'd1;
                size_err    <= ~count_ok;
            end
        end
    end

endmodule

// File: tb/tb_eee_hblur3.sv
// Self-checking bench for eee_hblur3 using a reduced 8x4 frame geometry.
module tb_eee_hblur3;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = 4;
    localparam int unsigned NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] sink_data = '0;
    logic        sink_valid = 1'b0;
    logic        sink_sop = 1'b0;
    logic        sink_eop = 1'b0;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_valid;
    logic        source_sop;
    logic        source_eop;
    logic        source_ready = 1'b1;
    logic        mode = 1'b1;
    logic [15:0] frame_count;
    logic        size_err;

    always #5 clk = ~clk;

    eee_hblur3 #(.IMAGE_W(W), .IMAGE_H(H)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_ready   (sink_ready),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_ready (source_ready),
        .mode         (mode),
        .frame_count  (frame_count),
        .size_err     (size_err)
    );

    typedef struct {
        int          grp;
        logic        md;
        logic        sop;
        logic        eop;
        logic [23:0] din;
        logic [23:0] dexp;
    } vec_t;

    vec_t        tbl[$];
    logic [25:0] stim[$];
    logic [25:0] expq[$];
    logic [25:0] got[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input int grp, input logic md, input logic sop, input logic eop,
                                input logic [23:0] din, input logic [23:0] dexp);
        vec_t v;
        v.grp = grp; v.md = md; v.sop = sop; v.eop = eop; v.din = din; v.dexp = dexp;
        tbl.push_back(v);
    endfunction

    // One bus cycle: drive at negedge, then sample both handshakes before posedge
    task automatic step(input bit drive, input logic [25:0] beat, input bit rnd, output bit acc);
        @(negedge clk);
        sink_valid = drive;
        {sink_sop, sink_eop, sink_data} = drive ? beat : 26'd0;
        source_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        acc = sink_valid & sink_ready;
        if (source_valid & source_ready) got.push_back({source_sop, source_eop, source_data});
    endtask

    task automatic run_stream(input string name, input bit rnd, input int budget);
        int          idx = 0;
        int          cyc = 0;
        bit          acc;
        logic [25:0] cur;
        got.delete();
        while ((idx < stim.size() || got.size() < stim.size()) && cyc < budget) begin
            cur = (idx < stim.size()) ? stim[idx] : 26'd0;
            step(idx < stim.size(), cur, rnd, acc);
            if (acc) idx++;
            cyc++;
        end
        check({name, "_budget"}, 32'(cyc < budget), 32'd1);
        repeat (4) step(1'b0, 26'd0, 1'b0, acc);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_count"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            check($sformatf("%s_beat%0d", name, i), 32'(got[i]), 32'(expq[i]));
        end
    endtask

    function automatic logic [7:0] avg3(input int l, input int c, input int r);
        return 8'((l + 2 * c + r) / 4);
    endfunction

    // Frame-level reference: each packet's pixels smoothed with edge replication
    task automatic build_expected(input bit md);
        int          n;
        int          i;
        int          s;
        int          e;
        int          x;
        bit          vid;
        logic [23:0] l;
        logic [23:0] c;
        logic [23:0] r;
        n = stim.size();
        i = 0;
        expq.delete();
        while (i < n) begin
            expq.push_back(stim[i]);
            if (!stim[i][25] || stim[i][24]) begin
                i++;
            end else begin
                vid = (stim[i][3:0] == 4'h0);
                s = i + 1;
                e = i;
                for (int k = s; k < n; k++) begin
                    if (stim[k][25]) break;
                    e = k;
                    if (stim[k][24]) break;
                end
                for (int k = s; k <= e; k++) begin
                    x = (k - s) % W;
                    c = stim[k][23:0];
                    l = (x == 0) ? c : stim[k-1][23:0];
                    r = (x == W - 1 || k == e) ? c : stim[k+1][23:0];
                    if (md && vid)
                        expq.push_back({stim[k][25:24],
                                        avg3(l[23:16], c[23:16], r[23:16]),
                                        avg3(l[15:8],  c[15:8],  r[15:8]),
                                        avg3(l[7:0],   c[7:0],   r[7:0])});
                    else
                        expq.push_back(stim[k]);
                end
                i = e + 1;
            end
        end
    endtask

    // Appends a video packet of npix random pixels, optionally without EOP
    task automatic push_frame(input int npix, input bit with_eop);
        stim.push_back({2'b10, 24'($urandom) & 24'hFFFFF0});
        for (int k = 0; k < npix; k++)
            stim.push_back({1'b0, with_eop && (k == npix - 1), 24'($urandom)});
    endtask

    initial begin
        bit acc;

        // Directed table: hand-computed outputs
        add(0, 1, 1, 0, 24'h000000, 24'h000000);
        add(0, 1, 0, 0, 24'h000000, 24'h000000);
        add(0, 1, 0, 0, 24'h000000, 24'h190000);
        add(0, 1, 0, 0, 24'h640000, 24'h320000);
        add(0, 1, 0, 0, 24'h000000, 24'h190000);
        add(0, 1, 0, 1, 24'h000000, 24'h000000);
        add(1, 1, 1, 0, 24'h000000, 24'h000000);
        add(1, 1, 0, 0, 24'hC80A00, 24'hA00F3F);
        add(1, 1, 0, 0, 24'h281EFF, 24'h46117F);
        add(1, 1, 0, 0, 24'h000000, 24'h0A073F);
        add(1, 1, 0, 0, 24'h000000, 24'h000000);
        add(1, 1, 0, 0, 24'h000000, 24'h000000);
        add(1, 1, 0, 0, 24'h000000, 24'h3F3F3F);
        add(1, 1, 0, 0, 24'hFFFFFF, 24'hBFBFBF);
        add(1, 1, 0, 0, 24'hFFFFFF, 24'hFFFFFF);
        add(1, 1, 0, 1, 24'h080402, 24'h080402);
        add(2, 1, 1, 0, 24'h00000F, 24'h00000F);
        add(2, 1, 0, 0, 24'h123456, 24'h123456);
        add(2, 1, 0, 1, 24'hABCDEF, 24'hABCDEF);
        add(3, 0, 1, 0, 24'h000000, 24'h000000);
        add(3, 0, 0, 0, 24'h000000, 24'h000000);
        add(3, 0, 0, 0, 24'h640000, 24'h640000);
        add(3, 0, 0, 1, 24'h000000, 24'h000000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_source_valid", 32'(source_valid), 32'd0);
        check("rst_source_data",  32'(source_data),  32'd0);
        check("rst_source_sop",   32'(source_sop),   32'd0);
        check("rst_source_eop",   32'(source_eop),   32'd0);
        check("rst_frame_count",  32'(frame_count),  32'd0);
        check("rst_size_err",     32'(size_err),     32'd0);
        check("rst_sink_ready",   32'(sink_ready),   32'd1);

        // EOP latency and single bubble (bypass, ready held high)
        mode = 1'b0;
        got.delete();
        step(1'b1, {2'b10, 24'h000000}, 1'b0, acc);
        check("lat_acc_sop", 32'(acc), 32'd1);
        step(1'b1, {2'b00, 24'h112233}, 1'b0, acc);
        check("lat_acc_a", 32'(acc), 32'd1);
        step(1'b1, {2'b01, 24'h445566}, 1'b0, acc);
        check("lat_acc_eop", 32'(acc), 32'd1);
        step(1'b0, 26'd0, 1'b0, acc);
        check("lat_bubble", 32'(sink_ready), 32'd0);
        step(1'b0, 26'd0, 1'b0, acc);
        check("lat_ready_back", 32'(sink_ready), 32'd1);
        check("lat_eop_out", {6'd0, source_valid, source_eop, source_data}, {6'd0, 2'b11, 24'h445566});
        check("lat_count", 32'(got.size()), 32'd3);
        check("lat_frame_count", 32'(frame_count), 32'd1);
        check("lat_size_err", 32'(size_err), 32'd1);
        repeat (2) step(1'b0, 26'd0, 1'b0, acc);

        // Table-driven packets
        for (int g = 0; g < 4; g++) begin
            stim.delete();
            expq.delete();
            foreach (tbl[i]) begin
                if (tbl[i].grp == g) begin
                    mode = tbl[i].md;
                    stim.push_back({tbl[i].sop, tbl[i].eop, tbl[i].din});
                    expq.push_back({tbl[i].sop, tbl[i].eop, tbl[i].dexp});
                end
            end
            run_stream($sformatf("tbl%0d", g), 1'b0, 200);
            compare_stream($sformatf("tbl%0d", g));
        end
        check("tbl_frame_count", 32'(frame_count), 32'd4);
        check("tbl_size_err", 32'(size_err), 32'd1);

        // Full frame under random backpressure
        mode = 1'b1;
        stim.delete();
        push_frame(NPIX, 1'b1);
        build_expected(1'b1);
        run_stream("full", 1'b1, 2000);
        compare_stream("full");
        check("full_frame_count", 32'(frame_count), 32'd5);
        check("full_size_err", 32'(size_err), 32'd0);

        // Short frame then a correct one
        stim.delete();
        push_frame(20, 1'b1);
        build_expected(1'b1);
        run_stream("short", 1'b1, 2000);
        compare_stream("short");
        check("short_size_err", 32'(size_err), 32'd1);
        check("short_frame_count", 32'(frame_count), 32'd6);
        stim.delete();
        push_frame(NPIX, 1'b1);
        build_expected(1'b1);
        run_stream("recover", 1'b1, 2000);
        compare_stream("recover");
        check("recover_size_err", 32'(size_err), 32'd0);
        check("recover_frame_count", 32'(frame_count), 32'd7);

        // Packet cut short by a new SOP
        stim.delete();
        push_frame(3, 1'b0);
        push_frame(NPIX, 1'b1);
        build_expected(1'b1);
        run_stream("trunc", 1'b0, 2000);
        compare_stream("trunc");
        check("trunc_frame_count", 32'(frame_count), 32'd8);
        check("trunc_size_err", 32'(size_err), 32'd0);

        // Reset pulse mid-line, then a clean frame
        stim.delete();
        push_frame(NPIX, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, stim[k], 1'b0, acc);
        @(negedge clk);
        sink_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rst_source_valid", 32'(source_valid), 32'd0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        check("mid_rst_sink_ready", 32'(sink_ready), 32'd1);
        stim.delete();
        push_frame(NPIX, 1'b1);
        build_expected(1'b1);
        run_stream("post_rst", 1'b0, 2000);
        compare_stream("post_rst");
        check("post_rst_frame_count", 32'(frame_count), 32'd1);
        check("post_rst_size_err", 32'(size_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
